onehot_scan_decoder: RTL and testbench
======================================

ONEHOT_SCAN_DECODER -- requirements
Module: onehot_scan_decoder

Interface
REQ-001 The block SHALL expose these parameters, one per line: name, default, meaning.
- SEL_W, 3, select width.
- NUM_OUT, 8, number of one-hot outputs; legal range 2..2**SEL_W.
- DWELL, 4, cycles each bit stays active in scan mode; legal range >= 1.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all logic on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- clr, in, 1, synchronous return to IDLE.
- mode, in, 1, 0 = direct decode, 1 = scan.
- en, in, 1, scan enable.
- in_valid, in, 1, sel is valid.
- sel, in, SEL_W, index to decode.
- in_ready, out, 1, block accepts sel this cycle.
- out, out, NUM_OUT, registered one-hot (or zero) output.
- out_valid, out, 1, out holds a decoded or scanned value.
- err, out, 1, one-cycle pulse: sel was out of range.
- wrap, out, 1, one-cycle pulse: scan wrapped to bit 0.

REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst).

Function
REQ-004 The block SHALL implement three states: IDLE, HOLD and SCAN.
REQ-005 in_ready SHALL be 1 in IDLE and HOLD when clr=0; it SHALL be 0 in SCAN or whenever clr=1 (combinational).
REQ-006 An input is accepted when in_valid && in_ready && mode==0.
REQ-007 For an accepted input with sel < NUM_OUT, the next cycle SHALL give out = 1<<sel, out_valid=1 and state HOLD (1-cycle latency).
REQ-008 For an accepted input with sel >= NUM_OUT, the next cycle SHALL give err=1 for one cycle; out and out_valid SHALL keep their previous values, and the state SHALL not change.
REQ-009 In HOLD, out SHALL hold its value until a new accepted input, clr, or entry into SCAN.
REQ-010 In IDLE or HOLD, mode==1 && en==1 (and clr=0) SHALL, on the next cycle:
- move to SCAN;
- set out = bit 0 and out_valid=1;
- clear the dwell counter to 0.
REQ-011 In SCAN, the dwell counter SHALL increment every cycle from 0 to DWELL-1. At DWELL-1 it SHALL reset to 0, and out SHALL rotate left by one bit on the next cycle.
REQ-012 When out = bit NUM_OUT-1 and the dwell counter is at DWELL-1:
- the next out SHALL be bit 0;
- wrap SHALL be 1 in that same cycle only.
REQ-013 With DWELL=1, the active bit SHALL advance every cycle.
REQ-014 In SCAN, mode==0 or en==0 SHALL, on the next cycle:
- give out=0 and out_valid=0;
- return to IDLE;
- clear the dwell counter.
REQ-015 clr=1 SHALL, from any state on the next cycle:
- force IDLE;
- set out=0, out_valid=0, err=0, wrap=0;
- clear the dwell counter.
clr SHALL take priority over in_valid, mode and en.
REQ-016 In IDLE with mode==1 and en==0, the block SHALL stay in IDLE; in_valid SHALL be ignored while mode==1.
REQ-017 Bits of out at or above NUM_OUT SHALL never be asserted; out SHALL be one-hot whenever out_valid=1 and all-zero whenever out_valid=0.
REQ-018 The dwell counter width SHALL be clog2(DWELL) (minimum 1).

Reset
REQ-019 With rst=1 at a rising edge, the next cycle SHALL give:
- state IDLE;
- out=0, out_valid=0, err=0, wrap=0;
- dwell counter 0.
REQ-020 rst SHALL take priority over clr and all other inputs, including mid-scan. After rst deasserts, the block SHALL accept input on the first cycle.

Verification
REQ-021 The bench SHALL cover these directed scenarios (defaults unless stated):
- Direct decode: mode=0, in_valid=1, sel=5 -> one cycle later out=8'b00100000, out_valid=1; hold 10 cycles with in_valid=0 -> out unchanged.
- Range error: NUM_OUT=6, sel=7 -> err=1 for exactly one cycle, previous out retained; then sel=2 -> out=6'b000100.
- Scan with wrap: mode=1, en=1, DWELL=4 -> bit 0 for 4 cycles, then bit 1 ... bit 7; on the 33rd cycle out returns to bit 0 with wrap=1 for one cycle.
- Scan exit: en drops while bit 3 is active -> next cycle out=0, out_valid=0, state IDLE; in_ready=1.
- Priority: clr=1 together with in_valid=1, sel=4 in HOLD -> in_ready=0, next out=0; rst asserted mid-scan -> all outputs 0 on the next cycle.
- DWELL=1, NUM_OUT=2 -> out alternates 01,10,01 each cycle, with wrap=1 on every return to 01.

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// One-hot decoder with registered output and a self-running scan mode.
// Scan holds each bit for DWELL cycles and wraps back to bit 0.
module onehot_scan_decoder #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DWELL   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               mode,
  input  logic               en,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] out,
  output logic               out_valid,
  output logic               err,
  output logic               wrap
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SCAN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NUM_OUT-1:0] r_out;
  logic [NUM_OUT-1:0] w_out_nxt;
  logic               r_vld;
  logic               w_vld_nxt;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;

  logic               w_ready;
  logic               w_accept;
  logic               w_in_rng;
  logic               w_scan_go;
  logic               w_scan_stop;
  logic [NUM_OUT-1:0] w_dec;

  assign w_ready     = (r_state != S_SCAN) && !clr;
  assign w_accept    = in_valid && w_ready && !mode;
  assign w_in_rng    = ({1'b0, sel} < (SEL_W + 1)'(NUM_OUT));
  assign w_scan_go   = mode && en;
  assign w_scan_stop = !mode || !en;
  assign w_dec       = NUM_OUT'(1) << sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_vld   <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_vld   <= w_vld_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept && w_in_rng) w_state_nxt = S_HOLD;
          else if (w_scan_go)       w_state_nxt = S_SCAN;
        end
        S_SCAN: begin
          if (w_scan_stop) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_out_nxt  = r_out;
    w_vld_nxt  = r_vld;
    w_cnt_nxt  = r_cnt;
    w_err_nxt  = 1'b0;
    w_wrap_nxt = 1'b0;
    if (clr) begin
      w_out_nxt = '0;
      w_vld_nxt = 1'b0;
      w_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            if (w_in_rng) begin
              w_out_nxt = w_dec;
              w_vld_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else if (w_scan_go) begin
            w_out_nxt = NUM_OUT'(1);
            w_vld_nxt = 1'b1;
            w_cnt_nxt = '0;
          end
        end
        S_SCAN: begin
          if (w_scan_stop) begin
            w_out_nxt = '0;
            w_vld_nxt = 1'b0;
            w_cnt_nxt = '0;
          end else if (r_cnt == LAST) begin
            w_cnt_nxt = '0;
            // Top bit rotates back to bit 0 and flags the wrap.
            if (r_out[NUM_OUT-1]) begin
              w_out_nxt  = NUM_OUT'(1);
              w_wrap_nxt = 1'b1;
            end else begin
              w_out_nxt = {r_out[NUM_OUT-2:0], 1'b0};
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_out_nxt = '0;
          w_vld_nxt = 1'b0;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign out       = r_out;
  assign out_valid = r_vld;
  assign err       = r_err;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: default, NUM_OUT=6
// and NUM_OUT=2/DWELL=1 instances share one stimulus stream.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       mode;
  logic       en;
  logic       in_valid;
  logic [2:0] sel;

  logic       rdy8, vld8, err8, wrp8;
  logic [7:0] out8;
  logic       rdy6, vld6, err6, wrp6;
  logic [5:0] out6;
  logic       rdy2, vld2, err2, wrp2;
  logic [1:0] out2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .en(en),
    .in_valid(in_valid), .sel(sel), .in_ready(rdy8),
    .out(out8), .out_valid(vld8), .err(err8), .wrap(wrp8)
  );

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(6), .DWELL(4)) u_dut6 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .en(en),
    .in_valid(in_valid), .sel(sel), .in_ready(rdy6),
    .out(out6), .out_valid(vld6), .err(err6), .wrap(wrp6)
  );

  onehot_scan_decoder #(.SEL_W(1), .NUM_OUT(2), .DWELL(1)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .en(en),
    .in_valid(in_valid), .sel(sel[0]), .in_ready(rdy2),
    .out(out2), .out_valid(vld2), .err(err2), .wrap(wrp2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; mode = 1'b0; en = 1'b0;
    in_valid = 1'b0; sel = '0;
    tick();
    tick();
    chk("rst_out", out8, 8'h00);
    chk("rst_vld", vld8, 1'b0);
    chk("rst_err", err8, 1'b0);
    chk("rst_wrap", wrp8, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", rdy8, 1'b1);

    // direct decode straight after reset release
    in_valid = 1'b1; sel = 3'd5;
    tick();
    chk("dec5_out", out8, 8'b0010_0000);
    chk("dec5_vld", vld8, 1'b1);
    chk("dec5_out6", out6, 6'b10_0000);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_out", out8, 8'b0010_0000);
    end
    chk("hold_vld", vld8, 1'b1);

    // range errors on NUM_OUT=6
    in_valid = 1'b1; sel = 3'd7;
    tick();
    chk("rng7_err", err6, 1'b1);
    chk("rng7_out", out6, 6'b10_0000);
    chk("rng7_vld", vld6, 1'b1);
    chk("rng7_err8", err8, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("rng7_pulse", err6, 1'b0);
    chk("rng7_keep", out6, 6'b10_0000);
    in_valid = 1'b1; sel = 3'd6;
    tick();
    chk("rng6_err", err6, 1'b1);
    chk("rng6_out", out6, 6'b10_0000);
    sel = 3'd2;
    tick();
    chk("rng2_out", out6, 6'b00_0100);
    chk("rng2_err", err6, 1'b0);

    // clr beats a valid input in HOLD
    sel = 3'd4; clr = 1'b1;
    #1;
    chk("clr_rdy", rdy8, 1'b0);
    tick();
    chk("clr_out", out8, 8'h00);
    chk("clr_vld", vld8, 1'b0);
    clr = 1'b0; in_valid = 1'b0;

    // mode=1 en=0 in IDLE ignores in_valid
    mode = 1'b1; in_valid = 1'b1; sel = 3'd3;
    tick();
    chk("m1_out", out8, 8'h00);
    chk("m1_vld", vld8, 1'b0);
    chk("m1_rdy", rdy8, 1'b1);
    in_valid = 1'b0;

    // scan with wrap, then exit while bit 3 is active
    en = 1'b1;
    for (int k = 1; k <= 46; k++) begin
      tick();
      chk("scan_out", out8, 32'(8'h01 << (((k - 1) / 4) % 8)));
      chk("scan_wrap", wrp8, (k == 33) ? 1'b1 : 1'b0);
    end
    chk("scan_vld", vld8, 1'b1);
    chk("scan_rdy", rdy8, 1'b0);
    en = 1'b0;
    tick();
    chk("exit_out", out8, 8'h00);
    chk("exit_vld", vld8, 1'b0);
    chk("exit_rdy", rdy8, 1'b1);

    // re-entry restarts dwell count; rst mid-scan
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("re_out", out8, (k <= 4) ? 8'h01 : 8'h02);
    end
    rst = 1'b1; clr = 1'b1;
    tick();
    chk("mrst_out", out8, 8'h00);
    chk("mrst_vld", vld8, 1'b0);
    chk("mrst_err", err8, 1'b0);
    chk("mrst_wrap", wrp8, 1'b0);

    // DWELL=1, NUM_OUT=2 alternation
    rst = 1'b0; clr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("d1_out", out2, (k % 2 == 1) ? 2'b01 : 2'b10);
      chk("d1_wrap", wrp2, (k % 2 == 1 && k > 1) ? 1'b1 : 1'b0);
      chk("d1_vld", vld2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
